// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared constants for the ALU control / mult-div slice: operation classes,
// R-type funct codes, ALUControl encodings and the engine state encoding.
package alu_ctrl_pkg;

  localparam int CTRL_W_P = 4;

  // Main-decoder operation classes
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_CLS5  = 3'b101;

  // Single-cycle R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  // Mult/div class funct codes
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  // ALUControl encodings
  localparam logic [CTRL_W_P-1:0] CTL_AND  = 4'b0000;
  localparam logic [CTRL_W_P-1:0] CTL_OR   = 4'b0001;
  localparam logic [CTRL_W_P-1:0] CTL_ADD  = 4'b0010;
  localparam logic [CTRL_W_P-1:0] CTL_JR   = 4'b0100;
  localparam logic [CTRL_W_P-1:0] CTL_CLS5 = 4'b0101;
  localparam logic [CTRL_W_P-1:0] CTL_SUB  = 4'b0110;
  localparam logic [CTRL_W_P-1:0] CTL_SLT  = 4'b0111;
  localparam logic [CTRL_W_P-1:0] CTL_SLL  = 4'b1000;
  localparam logic [CTRL_W_P-1:0] CTL_SRL  = 4'b1001;
  localparam logic [CTRL_W_P-1:0] CTL_NOR  = 4'b1100;
  localparam logic [CTRL_W_P-1:0] CTL_BAD  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

  // True for any funct handled by the HI/LO side (engine ops and moves)
  function automatic logic is_md_func(input logic [5:0] f);
    logic r;
    case (f)
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
      FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the four ops that run the iterative engine
  function automatic logic is_engine_func(input logic [5:0] f);
    return (f[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// EX-stage bus between the pipeline and the ALU control / mult-div block.
interface alu_ctrl_muldiv_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic [2:0]        ALUOp;
  logic [5:0]        func;
  logic              issue_en;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [CTRL_W-1:0] ALUControl;
  logic              illegal;
  logic              stall;
  logic              md_busy;
  logic              md_done;
  logic [WIDTH-1:0]  hilo_rdata;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  modport master (
    output ALUOp, func, issue_en, op_a, op_b,
    input  ALUControl, illegal, stall, md_busy, md_done, hilo_rdata, hi, lo
  );

  modport slave (
    input  ALUOp, func, issue_en, op_a, op_b,
    output ALUControl, illegal, stall, md_busy, md_done, hilo_rdata, hi, lo
  );
endinterface

// File: rtl/alu_ctrl_muldiv_muldiv_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step
// per cycle on magnitudes, sign correction in a final FIX cycle.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  md_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_hi_r;   // mult: partial high product; div: remainder
  logic [WIDTH-1:0] acc_lo_r;   // mult: multiplier/low product; div: dividend/quotient
  logic [WIDTH-1:0] opnd_r;     // multiplicand or divisor magnitude
  logic             is_div_r;
  logic             neg_q_r;    // negate product / quotient
  logic             neg_r_r;    // negate remainder
  logic             dz_r;       // divide by zero
  logic             busy_r;
  logic             done_r;

  logic [WIDTH:0]   shl_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] step_hi_s;
  logic [WIDTH-1:0] step_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic             sgn_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1'b1)) : v;
  endfunction

  assign sgn_s = ~is_unsigned;

  // One datapath step: shift-add for mult, restoring subtract for div
  always_comb begin
    shl_s     = {acc_hi_r, acc_lo_r[WIDTH-1]};
    diff_s    = shl_s[WIDTH-1:0] - opnd_r;
    sum_s     = '0;
    step_hi_s = acc_hi_r;
    step_lo_s = acc_lo_r;
    if (is_div_r) begin
      if (shl_s >= {1'b0, opnd_r}) begin
        step_hi_s = diff_s;
        step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_s = shl_s[WIDTH-1:0];
        step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum_s     = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      step_hi_s = sum_s[WIDTH:1];
      step_lo_s = {sum_s[0], acc_lo_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes; consumed only in FIX
  always_comb begin
    prod_s = {acc_hi_r, acc_lo_r};
    if (is_div_r) begin
      if (dz_r) begin
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_lo = neg_q_r ? (~acc_lo_r + WIDTH'(1'b1)) : acc_lo_r;
      end
      res_hi = neg_r_r ? (~acc_hi_r + WIDTH'(1'b1)) : acc_hi_r;
    end else begin
      if (neg_q_r) begin
        prod_s = ~prod_s + (2*WIDTH)'(1'b1);
      end else begin
        prod_s = {acc_hi_r, acc_lo_r};
      end
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end
  end

  // Engine FSM: IDLE -> RUN (WIDTH steps) -> FIX (write-back) -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      acc_hi_r <= '0;
      acc_lo_r <= '0;
      opnd_r   <= '0;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r  <= ST_RUN;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
            is_div_r <= is_div;
            acc_hi_r <= '0;
            neg_q_r  <= sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r  <= sgn_s & a[WIDTH-1];
            dz_r     <= is_div & (b == '0);
            if (is_div) begin
              acc_lo_r <= mag(a, sgn_s);
              opnd_r   <= mag(b, sgn_s);
            end else begin
              acc_lo_r <= mag(b, sgn_s);
              opnd_r   <= mag(a, sgn_s);
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_hi_r <= step_hi_s;
          acc_lo_r <= step_lo_s;
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_r <= ST_FIX;
            cnt_r   <= '0;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_FIX: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control: funct decode, mult/div hazard stall and the
// architectural HI/LO registers fed by the iterative engine or mthi/mtlo.
module alu_ctrl_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  alu_ctrl_muldiv_if.slave   bus
);

  logic [CTRL_W_P-1:0] ctl_s;
  logic                illegal_s;
  logic                md_op_s;
  logic                accept_s;
  logic                start_s;
  logic                md_busy_s;
  logic                md_done_s;
  logic [WIDTH-1:0]    res_hi_s;
  logic [WIDTH-1:0]    res_lo_s;
  logic [WIDTH-1:0]    hi_r;
  logic [WIDTH-1:0]    lo_r;

  // ALUOp/func decode; anything unlisted is flagged illegal
  always_comb begin
    ctl_s     = CTL_BAD;
    illegal_s = 1'b1;
    case (bus.ALUOp)
      ALUOP_ADD:  begin ctl_s = CTL_ADD;  illegal_s = 1'b0; end
      ALUOP_SUB:  begin ctl_s = CTL_SUB;  illegal_s = 1'b0; end
      ALUOP_AND:  begin ctl_s = CTL_AND;  illegal_s = 1'b0; end
      ALUOP_OR:   begin ctl_s = CTL_OR;   illegal_s = 1'b0; end
      ALUOP_CLS5: begin ctl_s = CTL_CLS5; illegal_s = 1'b0; end
      ALUOP_RTYPE: begin
        illegal_s = 1'b0;
        case (bus.func)
          FN_ADD:  ctl_s = CTL_ADD;
          FN_JR:   ctl_s = CTL_JR;
          FN_SUB:  ctl_s = CTL_SUB;
          FN_AND:  ctl_s = CTL_AND;
          FN_OR:   ctl_s = CTL_OR;
          FN_SLT:  ctl_s = CTL_SLT;
          FN_NOR:  ctl_s = CTL_NOR;
          FN_SLL:  ctl_s = CTL_SLL;
          FN_SRL:  ctl_s = CTL_SRL;
          default: begin
            if (is_md_func(bus.func)) begin
              ctl_s = CTL_ADD;
            end else begin
              ctl_s     = CTL_BAD;
              illegal_s = 1'b1;
            end
          end
        endcase
      end
      default: begin
        ctl_s     = CTL_BAD;
        illegal_s = 1'b1;
      end
    endcase
  end

  assign bus.ALUControl = CTRL_W'(ctl_s);
  assign bus.illegal    = illegal_s;

  // A HI/LO-class op waits while the engine is busy and is re-presented
  assign md_op_s   = bus.issue_en & (bus.ALUOp == ALUOP_RTYPE) & is_md_func(bus.func);
  assign bus.stall = md_op_s & md_busy_s;
  assign accept_s  = md_op_s & ~md_busy_s;
  assign start_s   = accept_s & is_engine_func(bus.func);

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv_iter (
    .clk         (clk),
    .reset       (reset),
    .start       (start_s),
    .is_div      (bus.func[1]),
    .is_unsigned (bus.func[0]),
    .a           (bus.op_a),
    .b           (bus.op_b),
    .busy        (md_busy_s),
    .done        (md_done_s),
    .res_hi      (res_hi_s),
    .res_lo      (res_lo_s)
  );

  // HI/LO: engine write-back in FIX, otherwise accepted mthi/mtlo
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (md_done_s) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else begin
      if (accept_s && (bus.func == FN_MTHI)) begin
        hi_r <= bus.op_a;
      end else begin
        hi_r <= hi_r;
      end
      if (accept_s && (bus.func == FN_MTLO)) begin
        lo_r <= bus.op_a;
      end else begin
        lo_r <= lo_r;
      end
    end
  end

  assign bus.hilo_rdata = (bus.func == FN_MFHI) ? hi_r : lo_r;
  assign bus.hi         = hi_r;
  assign bus.lo         = lo_r;
  assign bus.md_busy    = md_busy_s;
  assign bus.md_done    = md_done_s;

endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
Next-generation ALU control unit. It decodes ALUOp/func into an ALUControl code and adds a parametrised iterative multiply/divide engine that owns the HI/LO registers. It sits in the EX stage beside the main ALU. Single-cycle ops remain purely combinational. mult/div are multi-cycle, and the block stalls the pipeline while they run.

Parameters:
WIDTH, 32, datapath width; operand, HI and LO width
CTRL_W, 4, ALUControl width (widened from 3 to hold nor/sll/srl)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
ALUOp  in  3  main-decoder operation class
func  in  6  R-type funct field
issue_en  in  1  instruction valid in EX this cycle
op_a  in  WIDTH  rs operand
op_b  in  WIDTH  rt operand
ALUControl  out  CTRL_W  ALU operation select
illegal  out  1  undecodable ALUOp/func combination
stall  out  1  hold EX and upstream stages
md_busy  out  1  mult/div engine running
md_done  out  1  one-cycle pulse in the final (FIX) cycle
hilo_rdata  out  WIDTH  mfhi/mflo read data
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Decode is combinational. ALUOp 000 gives 0010 (add). 001 gives 0110 (sub). 011 gives 0000 (and). 100 gives 0001 (or). 101 gives 0101.
- ALUOp 010 decodes func: 100000 add 0010; 001000 jr 0100; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 101010 slt 0111; 100111 nor 1100; 000000 sll 1000; 000010 srl 1001.
- MD-class funcs (ALUOp 010): 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo. These drive ALUControl 0010 with illegal=0.
- Any other combination drives ALUControl=1111 and illegal=1. Never X.
- hilo_rdata = hi when func=010000, lo otherwise. Combinational.
- An MD op is accepted when issue_en=1, ALUOp=010, func is MD-class, and md_busy=0.
- stall = issue_en & ALUOp==010 & MD-class func & md_busy. A stalled op is not accepted, and the pipeline re-presents it. Non-MD ops never stall.
- mthi/mtlo: hi or lo takes op_a at the accepting edge.
- FSM states: IDLE, RUN, FIX.
  - IDLE: on accepting mult/multu/div/divu, latch operands and go to RUN with cnt=0. Signed ops latch magnitudes and record the result signs.
  - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle. Go to FIX when cnt==WIDTH-1.
  - FIX: apply sign correction, write hi/lo at the end of the cycle, assert md_done, return to IDLE.
- md_busy is high in RUN and FIX. For an op accepted at edge E, md_busy is high for WIDTH+1 cycles. New hi/lo are visible in the first cycle after that (34 cycles after E for WIDTH=32).
- mult: {hi,lo} = full 2*WIDTH product.
- div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero: lo = all ones, hi = dividend. Completes in normal latency.
- Reset (any state, including mid-operation): FSM to IDLE, cnt=0, hi=lo=0, md_busy=0, md_done=0, and all internal operand registers cleared. No partial write to hi/lo.
- While busy, hi/lo hold their old values until the FIX write.

Decomposition:
- Package alu_ctrl_pkg holds ALUOp class constants, funct constants (including MD-class), ALUControl codes (CTRL_W wide) and the FSM state encoding.
- One sub-module: muldiv_iter. It contains the FSM, counter, iterative mult/div datapath and sign fix.
- The top contains the decoder, the stall logic and the hi/lo registers, with mthi/mtlo muxed against the engine write.

Test Plan:
1. Decode sweep: every ALUOp plus every listed func. Check the exact ALUControl codes above. ALUOp=010, func=111111 gives 1111 and illegal=1. ALUOp=110 gives 1111 and illegal=1.
2. mult 7 x FFFFFFFD (-3): md_busy high 33 cycles, then hi=FFFFFFFF, lo=FFFFFFEB. multu FFFFFFFF x 2 gives hi=00000001, lo=FFFFFFFE.
3. div FFFFFFF9 (-7) / 2 gives lo=FFFFFFFD, hi=FFFFFFFF. divu 64/0 gives lo=FFFFFFFF, hi=00000040.
4. Hazard: issue mult, then mflo on the next cycle. stall=1 for every busy cycle and hilo_rdata holds the old lo. After md_done, mflo is accepted with stall=0 and returns the new lo. An add issued during busy gives stall=0.
5. mthi A5A5A5A5 then mfhi on the next cycle: hilo_rdata=A5A5A5A5. mtlo issued while busy gives stall=1, and lo is unchanged until the op is accepted.
6. Reset asserted at cycle 10 of a div: next cycle md_busy=0, hi=lo=0, md_done never pulses. A fresh multu 3 x 5 afterwards gives lo=0000000F, hi=0.
